// File: rtl/dmac_ch0_engine.sv
// DMA channel 0 transfer engine: AHB master moving words from source to destination
// with one single read followed by one single write per word.
module dmac_ch0_engine #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 12
) (
  input  logic              s_HCLK,
  input  logic              s_HRESETn,
  input  logic              dmac_en,
  input  logic              ch_en,
  input  logic [ADDR_W-1:0] ch_src,
  input  logic [ADDR_W-1:0] ch_dst,
  input  logic [CNT_W+2:0]  ch_ctrl,
  input  logic              intr_mask,
  input  logic              intr_clr,
  input  logic              m_HGRANT,
  input  logic              m_HREADY,
  input  logic [1:0]        m_HRESP,
  input  logic [31:0]       m_HRDATA,
  output logic              m_HBUSREQ,
  output logic [1:0]        m_HTRANS,
  output logic [ADDR_W-1:0] m_HADDR,
  output logic              m_HWRITE,
  output logic [2:0]        m_HSIZE,
  output logic [2:0]        m_HBURST,
  output logic [31:0]       m_HWDATA,
  output logic              ch_en_clr,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_left,
  output logic              tc_pend,
  output logic              err_pend,
  output logic              DMACINTR
);

  typedef enum logic [2:0] {IDLE, REQ, RD_A, RD_D, WR_A, WR_D, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [31:0]       buf_q;
  logic              arm_q;
  logic              en, start, resp_err, rd_ok, word_ok, last_word;
  logic [CNT_W-1:0]  cnt;

  assign en        = dmac_en & ch_en;
  assign cnt       = ch_ctrl[CNT_W-1:0];
  assign start     = (state_q == IDLE) & en & arm_q;
  assign resp_err  = (m_HRESP == 2'b01);
  assign rd_ok     = (state_q == RD_D) & m_HREADY & ~resp_err;
  assign word_ok   = (state_q == WR_D) & m_HREADY & ~resp_err;
  assign last_word = (xfer_left == CNT_W'(1));

  always_ff @(posedge s_HCLK or negedge s_HRESETn) begin
    if (!s_HRESETn) begin
      state_q   <= IDLE;
      arm_q     <= 1'b1;
      xfer_left <= '0;
      tc_pend   <= 1'b0;
      err_pend  <= 1'b0;
    end else begin
      state_q <= state_d;
      // A start needs the enables to have been low since the previous start.
      if (start)
        arm_q <= 1'b0;
      else if (!en)
        arm_q <= 1'b1;
      if (start)
        xfer_left <= cnt;
      else if (word_ok)
        xfer_left <= xfer_left - CNT_W'(1);
      if (state_q == DONE)
        tc_pend <= 1'b1;
      else if (intr_clr)
        tc_pend <= 1'b0;
      if (state_q == ERR)
        err_pend <= 1'b1;
      else if (intr_clr)
        err_pend <= 1'b0;
    end
  end

  always_ff @(posedge s_HCLK) begin
    if (start) begin
      src_q <= {ch_src[ADDR_W-1:2], 2'b00};
      dst_q <= {ch_dst[ADDR_W-1:2], 2'b00};
    end else if (word_ok) begin
      if (ch_ctrl[CNT_W])   src_q <= src_q + ADDR_W'(4);
      if (ch_ctrl[CNT_W+1]) dst_q <= dst_q + ADDR_W'(4);
    end
    if (rd_ok)
      buf_q <= m_HRDATA;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (cnt == '0) ? DONE : REQ;
      REQ:  if (m_HGRANT && m_HREADY) state_d = RD_A;
      RD_A: if (m_HREADY) state_d = RD_D;
      RD_D: begin
        if (resp_err)      state_d = ERR;
        else if (m_HREADY) state_d = WR_A;
      end
      WR_A: if (m_HREADY) state_d = WR_D;
      WR_D: begin
        if (resp_err)       state_d = ERR;
        else if (m_HREADY) begin
          if (last_word)     state_d = DONE;
          else if (!en)      state_d = IDLE;
          else if (m_HGRANT) state_d = RD_A;
          else               state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address is held through the data phase so it stays stable across wait states.
  always_comb begin
    m_HBUSREQ = 1'b0;
    m_HTRANS  = 2'b00;
    m_HADDR   = '0;
    m_HWRITE  = 1'b0;
    m_HWDATA  = '0;
    ch_en_clr = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      REQ: begin
        m_HBUSREQ = 1'b1;
        busy      = 1'b1;
      end
      RD_A, RD_D: begin
        m_HBUSREQ = 1'b1;
        busy      = 1'b1;
        m_HTRANS  = (state_q == RD_A) ? 2'b10 : 2'b00;
        m_HADDR   = src_q;
      end
      WR_A, WR_D: begin
        m_HBUSREQ = 1'b1;
        busy      = 1'b1;
        m_HTRANS  = (state_q == WR_A) ? 2'b10 : 2'b00;
        m_HADDR   = dst_q;
        m_HWRITE  = 1'b1;
        m_HWDATA  = (state_q == WR_D) ? buf_q : 32'h0;
      end
      DONE, ERR: ch_en_clr = 1'b1;
      default: ;
    endcase
  end

  assign m_HSIZE  = 3'b010;
  assign m_HBURST = 3'b000;
  assign DMACINTR = (tc_pend & ch_ctrl[CNT_W+2] & intr_mask) | err_pend;

endmodule

// File: doc/dmac_ch0_engine.md
Name: dmac_ch0_engine

Overview:
- Transfer engine for DMA channel 0: AHB master that moves 32-bit words from the channel source address to the destination address, one single read then one single write per word.
- Configured by the DMAC register bank (global config, C0 SrcAddr/DestAddr/Control/Configuration).
- Returns status and interrupt pending bits to the register bank for slave readback.
- Sits beside the DMAC AHB slave, on the master side of the same bus.

Parameters:
- ADDR_W, 32, AHB address width.
- CNT_W, 12, transfer-size field width (C0_Control[11:0]).

Ports:
- s_HCLK  in  1  bus clock
- s_HRESETn  in  1  reset, asynchronous, active-low
- dmac_en  in  1  DMAC_Configuration[0], global enable
- ch_en  in  1  DMAC_C0_Configuration[0], channel enable
- ch_src  in  32  DMAC_C0_SrcAddr
- ch_dst  in  32  DMAC_C0_DestAddr
- ch_ctrl  in  15  DMAC_C0_Control[14:0]: [11:0] word count, [12] SI, [13] DI, [14] TC interrupt enable
- intr_mask  in  1  1 = TC interrupt unmasked
- intr_clr  in  1  one-cycle pulse, clears tc_pend and err_pend
- m_HGRANT  in  1  arbiter grant
- m_HREADY  in  1  bus ready
- m_HRESP  in  2  slave response (OKAY=00, ERROR=01)
- m_HRDATA  in  32  read data
- m_HBUSREQ  out  1  bus request
- m_HTRANS  out  2  IDLE=00, NONSEQ=10
- m_HADDR  out  32  address
- m_HWRITE  out  1  write
- m_HSIZE  out  3  fixed 3'b010 (word)
- m_HBURST  out  3  fixed 3'b000 (SINGLE)
- m_HWDATA  out  32  write data
- ch_en_clr  out  1  one-cycle pulse; register bank clears C0 enable
- busy  out  1  channel active
- xfer_left  out  12  remaining word count
- tc_pend  out  1  terminal-count pending
- err_pend  out  1  bus-error pending
- DMACINTR  out  1  (tc_pend & ch_ctrl[14] & intr_mask) | err_pend

Behaviour:
- Reset: state IDLE. m_HBUSREQ=0, m_HTRANS=IDLE, m_HADDR=0, m_HWRITE=0, m_HWDATA=0, ch_en_clr=0, busy=0, xfer_left=0, tc_pend=0, err_pend=0, DMACINTR=0. Reset mid-transfer aborts immediately; no completion pulse.
- States: IDLE, REQ, RD_A, RD_D, WR_A, WR_D, DONE, ERR.
- IDLE:
  - If dmac_en & ch_en & count!=0: latch src/dst with [1:0] forced to 0, latch count into xfer_left, busy=1, go REQ.
  - If dmac_en & ch_en & count==0: go DONE with no bus activity.
- REQ: m_HBUSREQ=1. On m_HGRANT & m_HREADY, go RD_A. m_HBUSREQ stays 1 from REQ through the last WR_D.
- RD_A: HTRANS=NONSEQ, HADDR=src, HWRITE=0. On m_HREADY, go RD_D; otherwise hold.
- RD_D: HTRANS=IDLE.
  - HREADY & OKAY: capture m_HRDATA into the data buffer, go WR_A.
  - HRESP=ERROR: go ERR, checked on the first cycle ERROR is seen, regardless of HREADY.
- WR_A: HTRANS=NONSEQ, HADDR=dst, HWRITE=1. On m_HREADY, go WR_D.
- WR_D: HWDATA=buffer, held stable until HREADY. On HREADY & OKAY:
  - xfer_left -= 1.
  - src += 4 if SI; dst += 4 if DI. Addresses wrap modulo 2^32.
  - Then: xfer_left was 1 → DONE; else ch_en==0 (halt) → IDLE, busy=0, no tc_pend, xfer_left keeps the remaining count; else m_HGRANT → RD_A; else → REQ.
  - ERROR → ERR.
- DONE (1 cycle): tc_pend<=1, ch_en_clr=1, m_HBUSREQ=0, busy=0, go IDLE.
- ERR (1 cycle): err_pend<=1, ch_en_clr=1, m_HBUSREQ=0, busy=0, HTRANS=IDLE, go IDLE. xfer_left is frozen.
- Grant and enable changes: grant is sampled only in REQ and at the end of WR_D. ch_en or dmac_en dropping mid-word completes the current read/write pair, then halts.
- Pending bits: intr_clr clears tc_pend and err_pend. If set and clear occur in the same cycle, set wins.
- Restart: ch_en held high after ch_en_clr must not restart until it is deasserted for at least one cycle (rising-edge qualified start).

Test Plan:
- src=0x1000, dst=0x2000, count=3, SI=DI=1, grant tied 1, HREADY=1 → reads 0x1000/0x1004/0x1008, writes 0x2000/0x2004/0x2008 with matching data; tc_pend=1; ch_en_clr pulses once; xfer_left=0.
- count=2, DI=0, dst=0x3000 → both writes to 0x3000; HRDATA 0xA5A5A5A5 then 0x5A5A5A5A appear on HWDATA in order.
- Insert 3 HREADY=0 wait cycles in RD_D and WR_D → HADDR/HWDATA stable throughout; word count and addresses unchanged.
- HRESP=ERROR on 2nd read of count=4 → ERR; err_pend=1; DMACINTR=1; xfer_left=3; no further NONSEQ; intr_clr → DMACINTR=0.
- src=0xFFFFFFFC, count=2, SI=1 → second read at 0x00000000.
- Grant removed after word 1 of 3, restored 5 cycles later → engine waits in REQ with HBUSREQ=1; resumes at src+4; completes normally.
